// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the byte-lane helpers used by both the datapath and the storage.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Lane enables for an access; legal requests are naturally aligned, so the
  // shifted mask never spills past lane 7.
  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] lanes;
    case (size)
      SZ_B:    lanes = 8'h01;
      SZ_H:    lanes = 8'h03;
      SZ_W:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    return lanes << off;
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Core-side request/response bus of the data-memory responder.
interface dmem_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wr, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_sram.sv
// DEPTH x 64 single-port synchronous RAM with per-byte write enables.
// Each byte lane is its own array so every lane maps cleanly onto block RAM.
module dmem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (en) begin
          if (we[gi]) begin
            mem[addr] <= wdata[gi*8 +: 8];
          end
          q_reg <= mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, checks alignment
// and range, performs the SRAM access and holds the response until consumed.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] ADDR_BASE = 64'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_resp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ACCESS = ST_ACCESS;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0]    state_reg, state_next;
  logic          wr_reg;
  logic [1:0]    size_reg;
  logic [2:0]    off_reg;
  logic [AW-1:0] idx_reg;
  logic [63:0]   wdata_reg;
  logic          err_reg;

  logic [63:0] offset;
  logic        below_base;
  logic        beyond_top;
  logic        req_illegal;
  logic        accept;

  assign offset      = bus.req_addr - ADDR_BASE;
  assign below_base  = bus.req_addr < ADDR_BASE;
  assign beyond_top  = (offset >> 3) >= 64'(DEPTH);
  assign req_illegal = below_base | beyond_top | misaligned(bus.req_addr[2:0], bus.req_size);
  assign accept      = bus.req_valid && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = req_illegal ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      wr_reg    <= 1'b0;
      size_reg  <= SZ_B;
      off_reg   <= 3'd0;
      idx_reg   <= '0;
      wdata_reg <= 64'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        wr_reg    <= bus.req_wr;
        size_reg  <= bus.req_size;
        off_reg   <= bus.req_addr[2:0];
        idx_reg   <= offset[AW+2:3];
        wdata_reg <= bus.req_wdata;
        err_reg   <= req_illegal;
      end
    end
  end

  // The RAM is only enabled in ACCESS, so a reset that leaves ACCESS early
  // also cancels the pending write, and the read register holds during RESP.
  logic        sram_en;
  logic [7:0]  sram_we;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic [63:0] load_data;

  assign sram_en    = (state_reg == ACCESS);
  assign sram_we    = (sram_en && wr_reg) ? byte_en(size_reg, off_reg) : 8'h00;
  assign sram_wdata = wdata_reg << {off_reg, 3'b000};
  assign load_data  = (sram_rdata >> {off_reg, 3'b000}) & size_mask(size_reg);

  dmem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (idx_reg),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_err   = (state_reg == RESP) && err_reg;
  assign bus.rsp_rdata = ((state_reg == RESP) && !wr_reg && !err_reg) ? load_data : 64'd0;

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized scoreboard bench for dmem_resp against a byte-array memory model.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_resp_if bus ();

  dmem_resp #(
    .DEPTH     (DEPTH),
    .ADDR_BASE (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    time         acc;
    int          lat;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  bit   seen_g   = 0;
  bit   hold_req = 0;
  logic [7:0] mem_b [DEPTH*8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory and the legality rules in plain arithmetic.
  function automatic bit m_legal(input logic [63:0] a, input logic [1:0] s);
    logic [63:0] nb;
    nb = 64'd1 << s;
    if (a < BASE) return 0;
    if ((a - BASE) / 8 >= 64'(DEPTH)) return 0;
    if (a % nb != 0) return 0;
    return 1;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [1:0] s);
    logic [63:0] r;
    int base_i;
    r = 64'd0;
    base_i = int'(a - BASE);
    for (int i = 0; i < (1 << s); i++) r = r | (64'(mem_b[base_i + i]) << (8 * i));
    return r;
  endfunction

  task automatic m_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] wd);
    int base_i;
    base_i = int'(a - BASE);
    for (int i = 0; i < (1 << s); i++) mem_b[base_i + i] = wd[8*i +: 8];
  endtask

  task automatic issue(input bit wr, input logic [1:0] s, input logic [63:0] a,
                       input logic [63:0] wd, input bit expect_rsp,
                       input bit use_exp, input logic [63:0] er, input bit ee);
    int   w;
    exp_t e;
    bit   legal;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready) begin
      w++;
      if (w > 50) begin
        n_tests++; n_fail++;
        $display("FAIL req_ready_timeout: got 0 expected 1 within 50 cycles");
        return;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_size  = s;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    legal = m_legal(a, s);
    e.rdata = 64'd0;
    e.err   = !legal;
    e.lat   = legal ? 2 : 1;
    if (legal && expect_rsp) begin
      if (wr) m_store(a, s, wd);
      else    e.rdata = m_load(a, s);
    end
    if (use_exp) begin
      e.rdata = er;
      e.err   = ee;
    end
    @(posedge clk);
    e.acc = $time;
    if (expect_rsp) q.push_back(e);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || seen_g) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Monitor: pops the scoreboard on each new response, checks hold stability,
  // and drives rsp_ready (random, or held low when a stall test is armed).
  initial begin
    exp_t        e;
    bit          after_hs;
    logic [63:0] hold_d;
    logic        hold_e;
    int          hold_cnt;
    after_hs = 0;
    hold_cnt = 0;
    hold_d   = 64'd0;
    hold_e   = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (after_hs) begin
        check("ready_after_hs", 64'(bus.req_ready), 64'd1);
        after_hs = 0;
      end
      if (!rst_n) begin
        seen_g = 0;
        hold_cnt = 0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (bus.rsp_valid && !seen_g) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
        end else begin
          e = q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          check("latency", 64'(($time - e.acc + 5) / 10), 64'(e.lat));
          check("ready_busy", 64'(bus.req_ready), 64'd0);
        end
        seen_g   = 1;
        hold_d   = bus.rsp_rdata;
        hold_e   = bus.rsp_err;
        hold_cnt = hold_req ? 5 : 0;
        hold_req = 0;
      end else if (seen_g) begin
        check("valid_held", 64'(bus.rsp_valid), 64'd1);
        check("rdata_stable", bus.rsp_rdata, hold_d);
        check("err_stable", 64'(bus.rsp_err), 64'(hold_e));
        check("ready_busy", 64'(bus.req_ready), 64'd0);
      end
      if (hold_cnt > 0) begin
        bus.rsp_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus.rsp_ready = ($urandom % 3) != 0;
      end
      if (seen_g && bus.rsp_valid && bus.rsp_ready) begin
        seen_g   = 0;
        after_hs = 1;
      end
    end
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  s;
    int          r;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_size  = SZ_B;
    bus.req_addr  = 64'd0;
    bus.req_wdata = 64'd0;

    @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, SZ_D, BASE + 64'(8 * i), {$urandom, $urandom}, 1, 0, 64'd0, 1'b0);

    issue(1'b1, SZ_D, BASE + 64'h10, 64'h1122334455667788, 1, 1, 64'd0, 1'b0);
    issue(1'b0, SZ_W, BASE + 64'h14, 64'd0, 1, 1, 64'h11223344, 1'b0);
    issue(1'b1, SZ_B, BASE + 64'h13, 64'hAB, 1, 1, 64'd0, 1'b0);
    issue(1'b0, SZ_D, BASE + 64'h10, 64'd0, 1, 1, 64'h11223344AB667788, 1'b0);

    issue(1'b0, SZ_H, BASE + 64'h01, 64'd0, 1, 1, 64'd0, 1'b1);
    issue(1'b0, SZ_D, BASE, 64'd0, 1, 0, 64'd0, 1'b0);

    issue(1'b0, SZ_D, BASE + 64'(8 * DEPTH), 64'd0, 1, 1, 64'd0, 1'b1);
    issue(1'b1, SZ_D, BASE + 64'(8 * DEPTH), 64'hDEAD_BEEF_CAFE_F00D, 1, 1, 64'd0, 1'b1);
    issue(1'b1, SZ_D, BASE - 64'd8, 64'h0123_4567_89AB_CDEF, 1, 1, 64'd0, 1'b1);
    issue(1'b0, SZ_D, BASE, 64'd0, 1, 0, 64'd0, 1'b0);
    issue(1'b0, SZ_D, BASE + 64'(8 * (DEPTH - 1)), 64'd0, 1, 0, 64'd0, 1'b0);

    drain();
    hold_req = 1;
    issue(1'b0, SZ_W, BASE + 64'h10, 64'd0, 1, 0, 64'd0, 1'b0);
    drain();

    issue(1'b1, SZ_D, BASE + 64'h20, 64'hFFFF_0000_FFFF_0000, 0, 0, 64'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 64'(bus.req_ready), 64'd1);
    check("async_rst_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(1'b0, SZ_D, BASE + 64'h20, 64'd0, 1, 0, 64'd0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      s = 2'($urandom % 4);
      r = int'($urandom % 10);
      if (r == 0)      a = BASE - 64'd1 - 64'($urandom % 64);
      else if (r == 1) a = BASE + 64'(8 * DEPTH) + 64'($urandom % 64);
      else if (r == 2) a = BASE + 64'($urandom % (DEPTH * 8));
      else             a = BASE + (64'($urandom % (DEPTH * 8)) & ~((64'd1 << s) - 64'd1));
      issue(1'($urandom % 2), s, a, {$urandom, $urandom}, 1, 0, 64'd0, 1'b0);
    end

    drain();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
